uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two byte sources: port 0, the monitor (command echo and dump data), and port 1, the CPU output fifo drain. It arbitrates round-robin and drives tx_byte/transmit to the uart instance. It enforces a programmable inter-character gap, because the uart's is_transmitting flag alone does not pace reliably. It replaces the duplicated send/wait/counter logic in the monitor states.

Parameters:
GAP, 16'hfff, idle cycles inserted after is_transmitting falls before the next byte may start (0 = no gap)
CNT_WIDTH, 16, width of the gap counter and of sent_count

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
valid0  in  1  port 0 has a byte on data0
data0  in  8  port 0 byte
ack0  out  1  one-cycle pulse: data0 captured
valid1  in  1  port 1 has a byte on data1
data1  in  8  port 1 byte
ack1  out  1  one-cycle pulse: data1 captured
tx_byte  out  8  to uart tx_byte
transmit  out  1  to uart transmit, one-cycle pulse
is_transmitting  in  1  from uart is_transmitting
busy  out  1  high in any state other than IDLE
sent_count  out  CNT_WIDTH  bytes sent since reset, wraps modulo 2^CNT_WIDTH

Behaviour:
- All outputs are registered. Reset values: tx_byte=0, transmit=0, ack0=0, ack1=0, busy=0, sent_count=0, state=IDLE, gap counter=0, last_grant=1 (port 0 wins the first tie).
- rst takes priority over every other event. If asserted mid-operation, the FSM returns to IDLE next cycle and all pulses drop. A byte already handed to the uart completes, since the uart reset is separate.
- Requester rule: hold valid and data stable until ack. ack means the byte is consumed. valid may stay high with the next byte in the cycle after ack.
- States: IDLE, START, BUSY, GAP.
- IDLE:
  - Grant requires any valid and is_transmitting=0. Otherwise stay in IDLE.
  - Winner: if only one port is valid, that port wins. If both are valid, the port != last_grant wins.
  - At the next edge: tx_byte<=winner data, transmit<=1, ack<winner><=1, last_grant<=winner, sent_count<=sent_count+1, state<=START.
  - Latency from valid to transmit/ack is exactly 1 cycle.
- START: exactly one cycle, unconditional, to cover the uart flag lag. transmit and ack return to 0. Go to BUSY.
- BUSY:
  - Stay while is_transmitting=1.
  - When it is 0: if GAP=0 go to IDLE, else load counter<=GAP-1 and go to GAP.
- GAP: counter decrements once per cycle. When counter==0, go to IDLE. The gap is exactly GAP cycles.
- Minimum spacing between transmit pulses is 3+GAP cycles when is_transmitting is never seen high.
- valid changes during START/BUSY/GAP are ignored. Arbitration happens only in IDLE.
- A requester that drops valid before ack is simply not served. No byte is lost or duplicated.
- ack0 and ack1 are never high in the same cycle.
- transmit is never high in two consecutive cycles.

Test Plan:
1. Reset release, GAP=4, valid0=1, data0=8'h41, is_transmitting model high for 10 cycles after transmit -> transmit and ack0 pulse 1 cycle after valid0; tx_byte=8'h41; sent_count=1; busy high until 4 cycles after is_transmitting falls.
2. Both valid continuously (data0=8'h10, data1=8'h20), 4 bytes -> order port0, port1, port0, port1; ack0/ack1 never coincide; sent_count=4.
3. Only valid1 held with a new byte after each ack, 3 bytes 8'h01..8'h03 -> three grants to port 1 in order; each transmit is separated by ≥3+GAP cycles after is_transmitting low.
4. GAP=0 with is_transmitting always low -> transmit pulses exactly 3 cycles apart.
5. rst asserted during BUSY with valid0 high -> next cycle state IDLE, busy=0, sent_count=0, no ack. After rst drops, port 0 is granted first even if valid1 is also high.
6. Start with sent_count=16'hffff (CNT_WIDTH=16) and send one byte -> sent_count wraps to 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter between the
// monitor (port 0) and the CPU output fifo drain (port 1). Each byte is handed
// over as a one-cycle transmit pulse, and an inter-character gap is added
// after the uart reports idle.
module uart_tx_arbiter #(
  parameter int unsigned GAP       = 16'hfff,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid0,
  input  logic [7:0]           data0,
  output logic                 ack0,
  input  logic                 valid1,
  input  logic [7:0]           data1,
  output logic                 ack1,
  output logic [7:0]           tx_byte,
  output logic                 transmit,
  input  logic                 is_transmitting,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sent_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_GAP
  } state_t;

  // The gap counter counts down from GAP-1 to 0, which gives exactly GAP cycles.
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'(GAP - 1);

  state_t               state_q,      state_d;
  logic [CNT_WIDTH-1:0] gap_cnt_q,    gap_cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic [7:0]           tx_byte_q,    tx_byte_d;
  logic                 transmit_q,   transmit_d;
  logic                 ack0_q,       ack0_d;
  logic                 ack1_q,       ack1_d;
  logic                 busy_q,       busy_d;
  logic [CNT_WIDTH-1:0] sent_count_q, sent_count_d;
  logic                 grant1;

  // Next-state and output logic: arbitration happens only in IDLE. Pulses default to low.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    tx_byte_d    = tx_byte_q;
    sent_count_d = sent_count_q;
    transmit_d   = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    // If both ports are valid, the port that did not win last time gets the byte.
    grant1       = valid1 && (!valid0 || !last_grant_q);

    unique case (state_q)
      ST_IDLE: begin
        if ((valid0 || valid1) && !is_transmitting) begin
          tx_byte_d    = grant1 ? data1 : data0;
          transmit_d   = 1'b1;
          ack0_d       = !grant1;
          ack1_d       = grant1;
          last_grant_d = grant1;
          sent_count_d = sent_count_q + CNT_WIDTH'(1);
          state_d      = ST_START;
        end
      end
      // Wait one cycle so that is_transmitting from the uart has time to rise.
      ST_START: state_d = ST_BUSY;
      ST_BUSY: begin
        if (!is_transmitting) begin
          if (GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = GAP_LOAD;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, with a synchronous reset that takes priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    if (rst) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      tx_byte_q    <= 8'h00;
      transmit_q   <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      tx_byte_q    <= tx_byte_d;
      transmit_q   <= transmit_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign transmit   = transmit_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign busy       = busy_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Instance 0 uses GAP=4 and CNT_WIDTH=16. Instance 1
// uses GAP=0 and CNT_WIDTH=8, so that the sent_count wrap is reachable in a short run.
// A timestamp model predicts every output on every cycle, and directed tests
// pin the model with hand-computed values.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0 [2];
  logic       v1 [2];
  logic       itx [2];
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic       a0 [2];
  logic       a1 [2];
  logic       tr [2];
  logic       bz [2];
  logic [7:0] txb [2];
  logic [15:0] cnt_a;
  logic [7:0]  cnt_b;

  uart_tx_arbiter #(.GAP(4), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst),
    .valid0(v0[0]), .data0(d0[0]), .ack0(a0[0]),
    .valid1(v1[0]), .data1(d1[0]), .ack1(a1[0]),
    .tx_byte(txb[0]), .transmit(tr[0]), .is_transmitting(itx[0]),
    .busy(bz[0]), .sent_count(cnt_a)
  );

  uart_tx_arbiter #(.GAP(0), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst),
    .valid0(v0[1]), .data0(d0[1]), .ack0(a0[1]),
    .valid1(v1[1]), .data1(d1[1]), .ack1(a1[1]),
    .tx_byte(txb[1]), .transmit(tr[1]), .is_transmitting(itx[1]),
    .busy(bz[1]), .sent_count(cnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic int cnt_mask(input int k);
    return (k == 0) ? 32'hffff : 32'hff;
  endfunction

  function automatic int get_cnt(input int k);
    return (k == 0) ? int'(cnt_a) : int'(cnt_b);
  endfunction

  // ---------------- requesters: per-port byte queues ----------------
  logic [7:0] qa0[$], qa1[$], qb0[$], qb1[$];

  task automatic refresh();
    v0[0] = (qa0.size() != 0); d0[0] = v0[0] ? qa0[0] : 8'h00;
    v1[0] = (qa1.size() != 0); d1[0] = v1[0] ? qa1[0] : 8'h00;
    v0[1] = (qb0.size() != 0); d0[1] = v0[1] ? qb0[0] : 8'h00;
    v1[1] = (qb1.size() != 0); d1[1] = v1[1] ? qb1[0] : 8'h00;
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? qa0.size() + qa1.size() : qb0.size() + qb1.size();
  endfunction

  // A requester holds its byte until ack, then presents the next one.
  always @(negedge clk) begin
    if (a0[0] && qa0.size() != 0) void'(qa0.pop_front());
    if (a1[0] && qa1.size() != 0) void'(qa1.pop_front());
    if (a0[1] && qb0.size() != 0) void'(qb0.pop_front());
    if (a1[1] && qb1.size() != 0) void'(qb1.pop_front());
    refresh();
  end

  // ---------------- uart stand-in: flag high for ulen cycles, one cycle after transmit ----------------
  int ulen [2];
  int rem  [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tr[k]) begin
        rem[k] = ulen[k];
      end else if (rem[k] > 0) begin
        itx[k] = 1'b1;
        rem[k] = rem[k] - 1;
      end else begin
        itx[k] = 1'b0;
      end
    end
  end

  // ---------------- timestamp model ----------------
  // After a grant at edge g, the uart flag is examined from edge g+2 on. The
  // first edge f where it is low ends the byte. The arbiter is idle after edge
  // f+GAP, so the earliest next grant is at edge f+GAP+1.
  int  n = 0;
  bit  m_ok [2];
  bit  m_tr [2], m_a0 [2], m_a1 [2], m_busy [2], m_last [2];
  int  m_txb [2], m_cnt [2];
  bit  pend [2], fall_seen [2];
  int  g_edge [2], f_edge [2];

  always @(posedge clk) begin
    bit idle;
    bit win;
    n = n + 1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ok[k] = 1'b1; m_tr[k] = 1'b0; m_a0[k] = 1'b0; m_a1[k] = 1'b0;
        m_txb[k] = 0; m_cnt[k] = 0; m_busy[k] = 1'b0; m_last[k] = 1'b1;
        pend[k] = 1'b0; fall_seen[k] = 1'b0;
      end else begin
        m_tr[k] = 1'b0; m_a0[k] = 1'b0; m_a1[k] = 1'b0;
        if (pend[k] && !fall_seen[k] && n >= g_edge[k] + 2 && !itx[k]) begin
          fall_seen[k] = 1'b1;
          f_edge[k]    = n;
        end
        idle = !pend[k] || (fall_seen[k] && n > f_edge[k] + gap_of(k));
        if (idle && !itx[k] && (v0[k] || v1[k])) begin
          win       = (v0[k] && v1[k]) ? !m_last[k] : v1[k];
          m_txb[k]  = win ? int'(d1[k]) : int'(d0[k]);
          m_tr[k]   = 1'b1;
          m_a0[k]   = !win;
          m_a1[k]   = win;
          m_last[k] = win;
          m_cnt[k]  = (m_cnt[k] + 1) & cnt_mask(k);
          pend[k] = 1'b1; fall_seen[k] = 1'b0; g_edge[k] = n;
        end
        m_busy[k] = pend[k] && !(fall_seen[k] && n >= f_edge[k] + gap_of(k));
      end
    end
  end

  // ---------------- compare process: every cycle, both instances ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_ok[k]) begin
        check($sformatf("transmit[%0d]", k), 32'(tr[k]), 32'(m_tr[k]));
        check($sformatf("ack0[%0d]", k), 32'(a0[k]), 32'(m_a0[k]));
        check($sformatf("ack1[%0d]", k), 32'(a1[k]), 32'(m_a1[k]));
        check($sformatf("tx_byte[%0d]", k), 32'(txb[k]), 32'(m_txb[k]));
        check($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(m_busy[k]));
        check($sformatf("sent_count[%0d]", k), 32'(get_cnt(k)), 32'(m_cnt[k]));
        check($sformatf("ack_overlap[%0d]", k), 32'(a0[k] && a1[k]), 32'd0);
      end
    end
  end

  // ---------------- transmit log ----------------
  typedef struct {
    int         inst;
    int         port;
    logic [7:0] b;
    int         t;
  } log_t;
  log_t tlog[$];
  bit   tr_prev [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tr[k]) tlog.push_back('{k, a1[k] ? 1 : 0, txb[k], n});
      if (m_ok[k]) check($sformatf("transmit_back_to_back[%0d]", k), 32'(tr[k] && tr_prev[k]), 32'd0);
      tr_prev[k] = tr[k];
    end
  end

  // ---------------- helpers for the directed sequence ----------------
  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic drain(input int k, input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      done = (qsize(k) == 0) && !bz[k] && !itx[k];
    end
    check({name, "_drain_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  function automatic int entries(input int k);
    int c = 0;
    foreach (tlog[i]) if (tlog[i].inst == k) c++;
    return c;
  endfunction

  initial begin
    int   busy_cycles;
    int   idx;
    log_t la [$];
    ulen[0] = 10; ulen[1] = 0; rem[0] = 0; rem[1] = 0;
    itx[0] = 1'b0; itx[1] = 1'b0;
    refresh();
    step(2);

    // Reset values
    check("reset_tx_byte", 32'(txb[0]), 32'h00);
    check("reset_transmit", 32'(tr[0]), 32'd0);
    check("reset_busy", 32'(bz[0]), 32'd0);
    check("reset_sent_count", 32'(cnt_a), 32'd0);
    rst = 1'b0;
    step(1);

    // Test 1: a single byte on port 0 with GAP=4 and a 10-cycle uart flag
    qa0.push_back(8'h41); refresh();
    step(1);
    check("t1_transmit", 32'(tr[0]), 32'd1);
    check("t1_ack0", 32'(a0[0]), 32'd1);
    check("t1_tx_byte", 32'(txb[0]), 32'h41);
    check("t1_sent_count", 32'(cnt_a), 32'd1);
    // busy covers START + BUSY (2) + 10 flag cycles + GAP (4) = 16 cycles
    busy_cycles = 0;
    for (int i = 0; i < 40 && bz[0]; i++) begin
      busy_cycles++;
      step(1);
    end
    check("t1_busy_cycles", 32'(busy_cycles), 32'd16);
    drain(0, 100, "t1");

    // Test 2: both ports valid continuously; reset first so port 0 wins the first tie
    pulse_reset();
    tlog.delete();
    ulen[0] = 3;
    qa0.push_back(8'h10); qa0.push_back(8'h10);
    qa1.push_back(8'h20); qa1.push_back(8'h20);
    refresh();
    drain(0, 200, "t2");
    check("t2_count_entries", 32'(tlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < tlog.size(); i++) begin
      check($sformatf("t2_port_%0d", i), 32'(tlog[i].port), 32'(i % 2));
      check($sformatf("t2_byte_%0d", i), 32'(tlog[i].b), (i % 2 == 0) ? 32'h10 : 32'h20);
    end
    check("t2_sent_count", 32'(cnt_a), 32'd4);

    // Test 3: only port 1, three bytes, a 2-cycle uart flag -> spacing 3+GAP+2 = 9
    tlog.delete();
    ulen[0] = 2;
    qa1.push_back(8'h01); qa1.push_back(8'h02); qa1.push_back(8'h03); refresh();
    drain(0, 200, "t3");
    check("t3_count_entries", 32'(tlog.size()), 32'd3);
    for (int i = 0; i < 3 && i < tlog.size(); i++) begin
      check($sformatf("t3_port_%0d", i), 32'(tlog[i].port), 32'd1);
      check($sformatf("t3_byte_%0d", i), 32'(tlog[i].b), 32'(i + 1));
      if (i > 0) check($sformatf("t3_spacing_%0d", i), 32'(tlog[i].t - tlog[i-1].t), 32'd9);
    end

    // Test 4: GAP=0 instance with the uart flag always low -> pulses exactly 3 cycles apart
    tlog.delete();
    for (int i = 0; i < 4; i++) qb0.push_back(8'ha1 + 8'(i));
    refresh();
    drain(1, 100, "t4");
    check("t4_count_entries", 32'(entries(1)), 32'd4);
    for (int i = 1; i < 4 && i < tlog.size(); i++)
      check($sformatf("t4_spacing_%0d", i), 32'(tlog[i].t - tlog[i-1].t), 32'd3);

    // Test 5: reset during BUSY with valid0 still high; after reset port 0 wins over port 1
    tlog.delete();
    ulen[0] = 10;
    qa0.push_back(8'h55); qa0.push_back(8'h66); qa1.push_back(8'h77); refresh();
    idx = 0;
    for (int i = 0; i < 20 && tlog.size() == 0; i++) begin
      step(1);
      idx++;
    end
    check("t5_first_grant_seen", 32'(tlog.size()), 32'd1);
    step(3);
    rst = 1'b1;
    step(1);
    check("t5_busy_after_rst", 32'(bz[0]), 32'd0);
    check("t5_count_after_rst", 32'(cnt_a), 32'd0);
    check("t5_ack0_after_rst", 32'(a0[0]), 32'd0);
    rst = 1'b0;
    drain(0, 200, "t5");
    la.delete();
    foreach (tlog[i]) if (tlog[i].inst == 0) la.push_back(tlog[i]);
    check("t5_count_entries", 32'(la.size()), 32'd3);
    if (la.size() == 3) begin
      check("t5_first_byte", 32'(la[0].b), 32'h55);
      check("t5_after_rst_port", 32'(la[1].port), 32'd0);
      check("t5_after_rst_byte", 32'(la[1].b), 32'h66);
      check("t5_last_port", 32'(la[2].port), 32'd1);
    end
    check("t5_sent_count", 32'(cnt_a), 32'd2);

    // Test 6: 8-bit counter on instance 1 reaches all-ones, then one more byte wraps it to 0
    for (int i = 0; i < 255 - entries(1) + entries(1); i++) qb0.push_back(8'(i));
    refresh();
    drain(1, 1200, "t6a");
    check("t6_all_ones", 32'(cnt_b), 32'hff);
    qb1.push_back(8'h5a); refresh();
    drain(1, 50, "t6b");
    check("t6_wrap", 32'(cnt_b), 32'h00);
    check("t6_last_byte", 32'(txb[1]), 32'h5a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
